tt_spine_sel_ctrl: RTL and testbench

Break-before-make sequencer for the shared, buffered output spine of the multiplexer. It accepts project-select requests from the top-level control logic. Before pointing the spine at a new project it drops the spine drive enable and holds it low for a guard interval, so two projects never drive the high-drive spine buffers at once. Only then does it switch the select address and re-enable. It sits between the control front-end and the spine buffer enables and address decoders.

---
 rtl/tt_spine_sel_ctrl.sv | 74 +++++++
 tb/tb_tt_spine_sel_ctrl.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/tt_spine_sel_ctrl.sv
// tt_spine_sel_ctrl: break-before-make sequencer that guards spine enable around project-select changes
module tt_spine_sel_ctrl #(
  parameter int ADDR_W   = 10,
  parameter int NUM_PROJ = 512,
  parameter int GUARD    = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic              req_ena,
  output logic              req_ready,
  output logic [ADDR_W-1:0] sel_addr,
  output logic              sel_ena,
  output logic              busy,
  output logic              done,
  output logic              err
);
  typedef enum logic [1:0] {IDLE, DRAIN, SETTLE} state_t;
  localparam logic [ADDR_W:0] LIM    = (ADDR_W+1)'(NUM_PROJ);
  localparam logic [7:0]      RELOAD = 8'(GUARD - 1);
  state_t            state_q, state_d;
  logic [7:0]        cnt_q, cnt_d;
  logic [ADDR_W-1:0] sel_addr_q, sel_addr_d, pend_addr_q, pend_addr_d;
  logic              sel_ena_q, sel_ena_d, pend_ena_q, pend_ena_d;
  logic              done_q, done_d, err_q, err_d;
  logic              acc, bad, fast, full, drain_end, settle_end;
  assign acc        = req_valid && state_q == IDLE;
  assign bad        = acc && {1'b0, req_addr} >= LIM;
  assign fast       = acc && !bad && req_addr == sel_addr_q;
  assign full       = acc && !bad && req_addr != sel_addr_q;
  assign drain_end  = state_q == DRAIN && cnt_q == '0;
  assign settle_end = state_q == SETTLE && cnt_q == '0;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      sel_addr_q  <= '0;
      sel_ena_q   <= 1'b0;
      pend_addr_q <= '0;
      pend_ena_q  <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      sel_addr_q  <= sel_addr_d;
      sel_ena_q   <= sel_ena_d;
      pend_addr_q <= pend_addr_d;
      pend_ena_q  <= pend_ena_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end
  always_comb begin
    state_d = full ? DRAIN : drain_end ? SETTLE : settle_end ? IDLE : state_q;
  end
  always_comb begin
    cnt_d       = (full || drain_end) ? RELOAD :
                  (state_q != IDLE && cnt_q != '0) ? cnt_q - 8'd1 : cnt_q;
    sel_addr_d  = drain_end ? pend_addr_q : sel_addr_q;
    sel_ena_d   = fast ? req_ena : full ? 1'b0 : settle_end ? pend_ena_q : sel_ena_q;
    pend_addr_d = full ? req_addr : pend_addr_q;
    pend_ena_d  = full ? req_ena : pend_ena_q;
    done_d      = fast || settle_end;
    err_d       = bad;
  end
  assign req_ready = state_q == IDLE;
  assign busy      = !req_ready;
  assign sel_addr  = sel_addr_q;
  assign sel_ena   = sel_ena_q;
  assign done      = done_q;
  assign err       = err_q;
endmodule

// File: tb/tb_tt_spine_sel_ctrl.sv
// tb_tt_spine_sel_ctrl: vectors, corner sequences and a timeline model for the spine select sequencer
module tb_tt_spine_sel_ctrl;
  localparam int G  = 4;
  localparam int AW = 10;
  localparam int NP = 512;
  logic clk = 1'b0, rst = 1'b1;
  logic req_valid = 1'b0, req_ena = 1'b0;
  logic [AW-1:0] req_addr = '0;
  logic req_ready, sel_ena, busy, done, err;
  logic [AW-1:0] sel_addr;
  logic v1 = 1'b0, e1 = 1'b0;
  logic [AW-1:0] a1 = '0;
  logic r1_ready, r1_ena, r1_busy, r1_done, r1_err;
  logic [AW-1:0] r1_addr;
  always #5 clk = ~clk;
  tt_spine_sel_ctrl #(.ADDR_W(AW), .NUM_PROJ(NP), .GUARD(G)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_addr(req_addr), .req_ena(req_ena),
    .req_ready(req_ready), .sel_addr(sel_addr), .sel_ena(sel_ena), .busy(busy), .done(done), .err(err));
  tt_spine_sel_ctrl #(.ADDR_W(AW), .NUM_PROJ(NP), .GUARD(1)) dut_g1 (
    .clk(clk), .rst(rst), .req_valid(v1), .req_addr(a1), .req_ena(e1),
    .req_ready(r1_ready), .sel_addr(r1_addr), .sel_ena(r1_ena), .busy(r1_busy), .done(r1_done), .err(r1_err));
  typedef struct {
    int v; int a; int e;
    int xa; int xe; int xd; int xr; int xb;
  } vec_t;
  vec_t tv[8];
  int checks = 0, errors = 0;
  int m_addr, m_ena, m_busy, m_done, m_err, p_addr, p_ena, t_chg, t_end, n;
  int q_ena[$];
  int after, ndone, rv, ra, re, r;
  logic [AW-1:0] prev_a;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic drive(input int v, input int a, input int e);
    req_valid = v[0];
    req_addr  = a[AW-1:0];
    req_ena   = e[0];
  endtask
  task automatic do_reset();
    rst = 1'b1;
    drive(0, 0, 0);
    tick();
    tick();
    rst = 1'b0;
  endtask
  task automatic outs(input string tag, input int xa, input int xe, input int xd, input int xr, input int xb);
    chk({tag, "_addr"}, 32'(sel_addr), xa);
    chk({tag, "_ena"}, 32'(sel_ena), xe);
    chk({tag, "_done"}, 32'(done), xd);
    chk({tag, "_err"}, 32'(err), xr);
    chk({tag, "_busy"}, 32'(busy), xb);
    chk({tag, "_ready"}, 32'(req_ready), 32'(xb == 0));
  endtask
  task automatic model_reset();
    m_addr = 0; m_ena = 0; m_busy = 0; m_done = 0; m_err = 0;
    p_addr = 0; p_ena = 0; t_chg = -1; t_end = -1; n = 0;
  endtask
  // Timeline model: a full switch is a pair of scheduled events at accept+G and accept+2G.
  task automatic model_edge(input int v, input int a, input int e);
    n++;
    m_done = 0;
    m_err = 0;
    if (m_busy != 0) begin
      if (n == t_chg) m_addr = p_addr;
      if (n == t_end) begin
        m_ena = p_ena;
        m_done = 1;
        m_busy = 0;
      end
    end else if (v != 0) begin
      if (a >= NP) m_err = 1;
      else if (a == m_addr) begin
        m_ena = e;
        m_done = 1;
      end else begin
        m_busy = 1; p_addr = a; p_ena = e; m_ena = 0;
        t_chg = n + G; t_end = n + 2 * G;
      end
    end
  endtask
  initial begin
    tv[0] = '{0, 0, 0, 0, 0, 0, 0, 0};
    tv[1] = '{1, 0, 1, 0, 1, 1, 0, 0};
    tv[2] = '{1, 0, 0, 0, 0, 1, 0, 0};
    tv[3] = '{1, 600, 1, 0, 0, 0, 1, 0};
    tv[4] = '{1, 512, 1, 0, 0, 0, 1, 0};
    tv[5] = '{1, 0, 1, 0, 1, 1, 0, 0};
    tv[6] = '{1, 1023, 0, 0, 1, 0, 1, 0};
    tv[7] = '{0, 0, 0, 0, 1, 0, 0, 0};
    do_reset();
    outs("reset", 0, 0, 0, 0, 0);
    chk("reset_g1_ready", 32'(r1_ready), 1);
    for (int i = 0; i < 8; i++) begin
      drive(tv[i].v, tv[i].a, tv[i].e);
      tick();
      outs($sformatf("vec%0d", i), tv[i].xa, tv[i].xe, tv[i].xd, tv[i].xr, tv[i].xb);
    end
    do_reset();
    drive(1, 5, 1);
    v1 = 1'b1; a1 = 10'd3; e1 = 1'b1;
    tick();
    outs("full_e0", 0, 0, 0, 0, 1);
    drive(0, 0, 0);
    v1 = 1'b0;
    chk("g1_e0_busy", 32'(r1_busy), 1);
    chk("g1_e0_ena", 32'(r1_ena), 0);
    for (int k = 1; k < 2 * G; k++) begin
      tick();
      outs($sformatf("full_e%0d", k), (k >= G) ? 5 : 0, 0, 0, 0, 1);
      if (k == 1) begin
        chk("g1_e1_addr", 32'(r1_addr), 3);
        chk("g1_e1_ena", 32'(r1_ena), 0);
        chk("g1_e1_busy", 32'(r1_busy), 1);
      end
      if (k == 2) begin
        chk("g1_e2_ena", 32'(r1_ena), 1);
        chk("g1_e2_done", 32'(r1_done), 1);
        chk("g1_e2_busy", 32'(r1_busy), 0);
      end
    end
    tick();
    outs("full_e8", 5, 1, 1, 0, 0);
    drive(1, 5, 0);
    tick();
    outs("fast0", 5, 0, 1, 0, 0);
    drive(1, 5, 1);
    tick();
    outs("fast1", 5, 1, 1, 0, 0);
    drive(1, 600, 0);
    tick();
    outs("oor", 5, 1, 0, 1, 0);
    drive(0, 0, 0);
    tick();
    outs("oor_after", 5, 1, 0, 0, 0);
    drive(1, 7, 1);
    tick();
    outs("hold_e0", 5, 0, 0, 0, 1);
    tick();
    tick();
    drive(1, 9, 1);
    for (int k = 3; k <= 2 * G + 1; k++) begin
      tick();
      if (k == G) outs("hold_e4", 7, 0, 0, 0, 1);
      if (k == 2 * G) outs("hold_e8", 7, 1, 1, 0, 0);
      if (k == 2 * G + 1) outs("hold_e9", 7, 0, 0, 0, 1);
    end
    drive(0, 0, 0);
    for (int k = 2 * G + 2; k <= 4 * G + 1; k++) begin
      tick();
      if (k == 3 * G + 1) outs("hold_e13", 9, 0, 0, 0, 1);
      if (k == 4 * G + 1) outs("hold_e17", 9, 1, 1, 0, 0);
    end
    drive(1, 11, 1);
    tick();
    drive(0, 0, 0);
    for (int k = 1; k <= G + 1; k++) tick();
    outs("settle", 11, 0, 0, 0, 1);
    #2;
    rst = 1'b1;
    #1;
    outs("async_rst", 0, 0, 0, 0, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    ndone = 0;
    for (int k = 0; k < 3 * G; k++) begin
      tick();
      ndone += 32'(done);
    end
    chk("rst_no_done", ndone, 0);
    outs("rst_idle", 0, 0, 0, 0, 0);
    do_reset();
    model_reset();
    q_ena.delete();
    for (int i = 0; i < G; i++) q_ena.push_back(0);
    after = 0;
    prev_a = sel_addr;
    for (int k = 0; k < 3000; k++) begin
      rv = ($urandom_range(0, 3) != 0) ? 1 : 0;
      r = int'($urandom_range(0, 9));
      ra = (r < 4) ? int'($urandom_range(0, 3)) : (r < 6) ? int'($urandom_range(NP, 1023)) : int'($urandom_range(0, NP - 1));
      re = int'($urandom_range(0, 1));
      drive(rv, ra, re);
      tick();
      model_edge(rv, ra, re);
      outs("rand", m_addr, m_ena, m_done, m_err, m_busy);
      if (sel_addr !== prev_a) begin
        chk("inv_chg_ena", 32'(sel_ena), 0);
        foreach (q_ena[i]) chk("inv_pre_ena", q_ena[i], 0);
        after = G - 1;
      end else if (after > 0) begin
        chk("inv_post_ena", 32'(sel_ena), 0);
        after--;
      end
      chk("rand_done_err_excl", 32'(done && err), 0);
      q_ena.push_back(32'(sel_ena));
      if (q_ena.size() > G) void'(q_ena.pop_front());
      prev_a = sel_addr;
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
